// File: rtl/alu_mc.sv
// alu_mc: single-clock registered ALU with an iterative unsigned multiplier.
//
// Ports:
//   clk, rst_n      system clock (rising edge), async active-low reset
//   ld_a, ld_b      load Data_A / Data_B into A / B (ignored while busy)
//   Data_A, Data_B  operand inputs
//   ALU_OP, start   operation select and request, sampled together
//   A, B            operand registers
//   F, hi           result register; {hi,F} is the full MUL product
//   FR              flags {ZF, SF, CF, OF}
//   busy            high while a MUL is iterating
//   done            one-cycle pulse when F/FR have just been written
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic [WIDTH-1:0] Data_A,
  input  logic [WIDTH-1:0] Data_B,
  input  logic [3:0]       ALU_OP,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] hi,
  output logic [3:0]       FR,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111,
    OP_SUB  = 4'b1000,
    OP_MUL  = 4'b1010,
    OP_SRA  = 4'b1101
  } op_e;

  state_e state, state_next;
  op_e    op;

  logic [WIDTH-1:0] mcand, mplier, acc_hi, acc_lo;
  logic [CW-1:0]    cnt;

  logic accept_op, accept_mul, mul_step, mul_last;

  assign op   = op_e'(ALU_OP);
  assign busy = (state == S_MUL);

  // Combinational single-cycle ALU on the current A/B registers
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_w;
  logic [WIDTH-1:0] sub_w;
  logic [WIDTH-1:0] alu_f;
  logic             alu_cf, alu_of;
  logic [3:0]       alu_fr;

  assign shamt = B[SHW-1:0];
  assign add_w = {1'b0, A} + {1'b0, B};
  assign sub_w = A - B;

  always_comb begin
    alu_f  = '0;
    alu_cf = 1'b0;
    alu_of = 1'b0;
    case (op)
      OP_ADD: begin
        alu_f  = add_w[WIDTH-1:0];
        alu_cf = add_w[WIDTH];
        alu_of = (A[WIDTH-1] == B[WIDTH-1]) && (add_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_f  = sub_w;
        alu_cf = (A < B);
        alu_of = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLL:  alu_f = A << shamt;
      OP_SRL:  alu_f = A >> shamt;
      OP_SRA:  alu_f = $signed(A) >>> shamt;
      OP_SLT:  alu_f = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_f = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_XOR:  alu_f = A ^ B;
      OP_OR:   alu_f = A | B;
      OP_AND:  alu_f = A & B;
      default: alu_f = '0;
    endcase
  end

  // Illegal codes leave F=0, so the generic flag rule yields 4'b1000
  assign alu_fr = {(alu_f == '0), alu_f[WIDTH-1], alu_cf, alu_of};

  // Shift-add step: LSB-first multiplier; the accumulator's low bit
  // shifts down into acc_lo, which becomes F after WIDTH steps.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] acc_hi_n, acc_lo_n;

  assign mul_sum  = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_hi_n = mul_sum[WIDTH:1];
  assign acc_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept_op  = 1'b0;
    accept_mul = 1'b0;
    mul_step   = 1'b0;
    mul_last   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            accept_mul = 1'b1;
            state_next = S_MUL;
          end else begin
            accept_op = 1'b1;
          end
        end
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (cnt == CW'(1)) begin
          mul_last   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A      <= '0;
      B      <= '0;
      F      <= '0;
      hi     <= '0;
      FR     <= '0;
      done   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;

      if (state == S_IDLE) begin
        if (ld_a) A <= Data_A;
        if (ld_b) B <= Data_B;
      end

      if (accept_op) begin
        F    <= alu_f;
        FR   <= alu_fr;
        done <= 1'b1;
      end

      if (accept_mul) begin
        mcand  <= A;
        mplier <= B;
        acc_hi <= '0;
        acc_lo <= '0;
        cnt    <= CW'(WIDTH);
      end

      if (mul_step) begin
        acc_hi <= acc_hi_n;
        acc_lo <= acc_lo_n;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end

      if (mul_last) begin
        hi   <= acc_hi_n;
        F    <= acc_lo_n;
        FR   <= {(acc_lo_n == '0), acc_lo_n[WIDTH-1], (acc_hi_n != '0), 1'b0};
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=32).
module tb_alu_mc;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic          ld_a, ld_b, start;
  logic [W-1:0]  Data_A, Data_B;
  logic [3:0]    ALU_OP;
  logic [W-1:0]  A, B, F, hi;
  logic [3:0]    FR;
  logic          busy, done;

  int n_checks = 0;
  int n_errors = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_a   (ld_a),
    .ld_b   (ld_b),
    .Data_A (Data_A),
    .Data_B (Data_B),
    .ALU_OP (ALU_OP),
    .start  (start),
    .A      (A),
    .B      (B),
    .F      (F),
    .hi     (hi),
    .FR     (FR),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ab(input logic [W-1:0] a, input logic [W-1:0] b);
    ld_a = 1'b1; ld_b = 1'b1; Data_A = a; Data_B = b;
    tick();
    ld_a = 1'b0; ld_b = 1'b0;
    check("ld A", {32'h0, A}, {32'h0, a});
    check("ld B", {32'h0, B}, {32'h0, b});
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [W-1:0] ef, input logic [3:0] efr);
    logic [W-1:0] hi0;
    hi0 = hi;
    ALU_OP = op; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " done"}, {63'h0, done}, 64'h1);
    check({tag, " busy"}, {63'h0, busy}, 64'h0);
    check({tag, " F"},    {32'h0, F},    {32'h0, ef});
    check({tag, " FR"},   {60'h0, FR},   {60'h0, efr});
    check({tag, " hi"},   {32'h0, hi},   {32'h0, hi0});
    tick();
    check({tag, " done drop"}, {63'h0, done}, 64'h0);
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] ehi,
                         input logic [W-1:0] ef, input logic [3:0] efr, input bit poke);
    logic [W-1:0] a0, f0, hi0;
    logic [3:0]   fr0;
    int busy_cyc;
    int extra_done;
    int i;
    a0 = A; f0 = F; hi0 = hi; fr0 = FR;
    busy_cyc = 0; extra_done = 0; i = 0;
    ALU_OP = 4'b1010; start = 1'b1;
    tick();
    start = 1'b0;
    while (busy === 1'b1 && i < 100) begin
      busy_cyc++;
      if (done !== 1'b0) extra_done++;
      if (i == 2) begin
        check({tag, " F held"},  {32'h0, F},  {32'h0, f0});
        check({tag, " hi held"}, {32'h0, hi}, {32'h0, hi0});
        check({tag, " FR held"}, {60'h0, FR}, {60'h0, fr0});
      end
      if (poke && i == 4) begin
        start = 1'b1; ld_a = 1'b1; Data_A = 32'h1234_5678; ALU_OP = 4'b0000;
      end
      if (poke && i == 5) begin
        start = 1'b0; ld_a = 1'b0;
      end
      tick();
      i++;
    end
    check({tag, " busy cycles"}, 64'(busy_cyc), 64'd32);
    check({tag, " done while busy"}, 64'(extra_done), 64'd0);
    check({tag, " done"}, {63'h0, done}, 64'h1);
    check({tag, " hi"},   {32'h0, hi},   {32'h0, ehi});
    check({tag, " F"},    {32'h0, F},    {32'h0, ef});
    check({tag, " FR"},   {60'h0, FR},   {60'h0, efr});
    check({tag, " A frozen"}, {32'h0, A}, {32'h0, a0});
    tick();
    check({tag, " done drop"}, {63'h0, done}, 64'h0);
    check({tag, " busy idle"}, {63'h0, busy}, 64'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " A"},    {32'h0, A},    64'h0);
    check({tag, " B"},    {32'h0, B},    64'h0);
    check({tag, " F"},    {32'h0, F},    64'h0);
    check({tag, " hi"},   {32'h0, hi},   64'h0);
    check({tag, " FR"},   {60'h0, FR},   64'h0);
    check({tag, " busy"}, {63'h0, busy}, 64'h0);
    check({tag, " done"}, {63'h0, done}, 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen;
    rst_n = 1'b0; ld_a = 1'b0; ld_b = 1'b0; start = 1'b0;
    Data_A = '0; Data_B = '0; ALU_OP = '0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    load_ab(32'hFFFF_FFFF, 32'h0000_0001);
    run_op("add carry", 4'b0000, 32'h0000_0000, 4'b1010);
    load_ab(32'h8000_0000, 32'h8000_0000);
    run_op("add ovf", 4'b0000, 32'h0000_0000, 4'b1011);
    load_ab(32'h1, 32'h3);
    run_op("sub 1-3", 4'b1000, 32'hFFFF_FFFE, 4'b0110);
    load_ab(32'h3, 32'h1);
    run_op("sub 3-1", 4'b1000, 32'h0000_0002, 4'b0000);
    load_ab(32'h8000_0000, 32'h5);
    run_op("sra", 4'b1101, 32'hFC00_0000, 4'b0100);
    run_op("srl", 4'b0101, 32'h0400_0000, 4'b0000);
    load_ab(32'h1, 32'h5);
    run_op("sll", 4'b0001, 32'h0000_0020, 4'b0000);
    load_ab(32'h1, 32'hFFFF_FFFF);
    run_op("slt", 4'b0010, 32'h0, 4'b1000);
    run_op("sltu", 4'b0011, 32'h1, 4'b0000);
    load_ab(32'hF0F0_00FF, 32'h0FF0_0F0F);
    run_op("xor", 4'b0100, 32'hFF00_0FF0, 4'b0100);
    run_op("or",  4'b0110, 32'hFFF0_0FFF, 4'b0100);
    run_op("and", 4'b0111, 32'h00F0_000F, 4'b0000);

    // load and start together: op sees the old A, A still loads
    ALU_OP = 4'b0000; start = 1'b1; ld_a = 1'b1; Data_A = 32'h5;
    tick();
    start = 1'b0; ld_a = 1'b0;
    check("ld+start F",    {32'h0, F},    64'h0000_0000_00E0_100E);
    check("ld+start FR",   {60'h0, FR},   64'h2);
    check("ld+start done", {63'h0, done}, 64'h1);
    check("ld+start A",    {32'h0, A},    64'h5);
    tick();

    load_ab(32'h7, 32'h6);
    run_mul("mul 7*6", 32'h0, 32'h2A, 4'b0000, 1'b0);
    load_ab(32'h0001_0000, 32'h0001_0000);
    run_mul("mul 2^32", 32'h1, 32'h0, 4'b1010, 1'b0);
    load_ab(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mul("mul max", 32'hFFFF_FFFE, 32'h0000_0001, 4'b0010, 1'b1);

    load_ab(32'h1, 32'h1);
    run_op("illegal", 4'b1111, 32'h0, 4'b1000);

    // reset in the middle of a multiply
    load_ab(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    ALU_OP = 4'b1010; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("mid-mul busy", {63'h0, busy}, 64'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid-mul reset");
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("post-reset quiet", 64'(seen), 64'd0);
    load_ab(32'h3, 32'h4);
    run_op("add 3+4", 4'b0000, 32'h7, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
